ext_mem_responder: RTL and testbench
====================================

Name: ext_mem_responder

Overview:
Synthesizable responder end of the CPU external memory interface. It accepts read and write requests from the processor's memory port, holds line data in an internal line-addressed RAM, and merges write data under a byte mask. It returns read data with the original tag after a fixed pipeline latency. It sits between riscv_top and on-chip backing SRAM, replacing the behavioural memory model for FPGA and gate-level runs.

Parameters:
ADDR_BITS, 28, line address width (each line is 16 bytes).
DATA_BITS, 128, line data width.
TAG_BITS, 5, request tag width.
DEPTH_LOG2, 12, log2 of the internal line count.
LATENCY, 4, cycles from read-request acceptance to mem_resp_valid; legal range 1..16.

Ports:
clk  in  1  clock, all state on posedge
reset_n  in  1  asynchronous active-low reset
mem_req_valid  in  1  request valid
mem_req_ready  out  1  request accepted when valid&ready
mem_req_rw  in  1  1=write, 0=read
mem_req_addr  in  ADDR_BITS  line address
mem_req_tag  in  TAG_BITS  request tag
mem_req_data_valid  in  1  write data beat valid
mem_req_data_ready  out  1  write data beat accepted when valid&ready
mem_req_data_bits  in  DATA_BITS  write data
mem_req_data_mask  in  DATA_BITS/8  byte enables, bit i covers byte i
mem_resp_valid  out  1  read response valid (single cycle, no backpressure)
mem_resp_tag  out  TAG_BITS  tag of the returned read
mem_resp_data  out  DATA_BITS  read line data
rd_count  out  32  accepted reads
wr_count  out  32  completed writes
addr_err  out  1  sticky out-of-range flag

Behaviour:
- Reset (reset_n low, async): state=IDLE; mem_req_ready=0 while reset is asserted, 1 in IDLE afterwards; mem_req_data_ready=0; mem_resp_valid=0; mem_resp_tag=0; mem_resp_data=0; rd_count=0; wr_count=0; addr_err=0; the latency pipeline is cleared. RAM contents are not reset.
- Asserting reset mid-operation drops any pending write and all in-flight reads; no response is emitted for them.
- FSM states: IDLE, WDATA.
- IDLE: mem_req_ready=1, mem_req_data_ready=0.
  - Read accept: RAM row addr[DEPTH_LOG2-1:0] is sampled the same cycle. {tag, data} enters pipeline stage 0. rd_count increments. State stays IDLE.
  - Write accept: addr is latched. rd_count is unchanged. Next state is WDATA.
- WDATA: mem_req_ready=0, mem_req_data_ready=1. On a data beat, bytes with mask=1 are written to the latched row and bytes with mask=0 keep their old value. wr_count increments. Next state is IDLE.
- The data channel is never ready in IDLE. A data beat offered early simply waits.
- Ordering: a read accepted after a write sees the merged data. This holds because no request is accepted before the write's data beat completes.
- Latency: a read accepted on edge N produces mem_resp_valid=1 for exactly one cycle after edge N+LATENCY. Responses are strictly in order. Back-to-back reads give back-to-back responses.
- There is no resp_ready. The consumer must always accept responses.
- Out of range: any accepted request with addr[ADDR_BITS-1:DEPTH_LOG2] != 0 sets addr_err, which stays set until reset.
  - A read still returns its tag on schedule, with data=0.
  - A write still consumes its data beat, but RAM is not written and wr_count is not incremented.
- Counters wrap from 0xFFFFFFFF to 0.
- mem_resp_tag and mem_resp_data hold their last value when mem_resp_valid=0. The bench must not check them in that case.
- Writes produce no response.

Test Plan:
- Write then read: write addr 0x10, data 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0xFFFF, tag 3; then read addr 0x10, tag 7 -> one cycle of mem_resp_valid LATENCY(4) cycles after the read is accepted, tag 7, same data; wr_count=1, rd_count=1.
- Masked merge: line 0x20 holds all 0xFF; write data 0, mask 0x00F0 -> a read returns 0xFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF (bytes 4..7 cleared).
- Pipeline: 6 reads on consecutive cycles, tags 0..5 -> 6 consecutive response cycles with tags 0..5 in order, the first at accept+4.
- Write handshake: write accepted, data_valid held low for 5 cycles -> mem_req_ready=0 throughout, data_ready=1; a read offered meanwhile is not accepted until the cycle after the data beat.
- Out of range: read addr 0x1000 (DEPTH_LOG2=12), tag 9 -> response tag 9, data 0, addr_err=1 and stays set across later legal requests.
- Async reset: pulse reset_n low with 2 reads in flight and the FSM in WDATA -> all outputs return to their reset values immediately, no responses arrive for the in-flight reads, state is IDLE, both counters are 0.

Source files
------------

// File: rtl/ext_mem_responder.sv
// Line-addressed memory responder: byte-masked writes, tagged reads returned after LATENCY cycles.
// One request at a time; a write blocks new requests until its data beat lands; responses have no backpressure.
module ext_mem_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int TAG_BITS   = 5,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [TAG_BITS-1:0]    mem_resp_tag,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [31:0]            rd_count,
  output logic [31:0]            wr_count,
  output logic                   addr_err
);

  localparam int NBYTES = DATA_BITS / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic {IDLE, WDATA} state_t;

  state_t                  state, state_nxt;
  logic [DATA_BITS-1:0]    ram [DEPTH];
  logic [DEPTH_LOG2-1:0]   req_row, wr_row;
  logic                    req_oor, wr_oor;
  logic                    rd_fire, wr_fire, beat_fire;
  logic [LATENCY-1:0]      pipe_vld, pipe_oor;
  logic [TAG_BITS-1:0]     pipe_tag [LATENCY];
  logic [DATA_BITS-1:0]    pipe_dat [LATENCY];

  assign req_row   = mem_req_addr[DEPTH_LOG2-1:0];
  assign req_oor   = |mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];
  assign rd_fire   = mem_req_valid & mem_req_ready & ~mem_req_rw;
  assign wr_fire   = mem_req_valid & mem_req_ready & mem_req_rw;
  assign beat_fire = mem_req_data_valid & mem_req_data_ready;

  // Ready is gated by reset_n so nothing is offered while reset is held.
  always_comb begin
    state_nxt          = state;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    case (state)
      IDLE: begin
        mem_req_ready = reset_n;
        if (wr_fire) state_nxt = WDATA;
      end
      WDATA: begin
        mem_req_data_ready = 1'b1;
        if (mem_req_data_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rd_count       <= '0;
      wr_count       <= '0;
      addr_err       <= 1'b0;
      wr_row         <= '0;
      wr_oor         <= 1'b0;
      pipe_vld       <= '0;
      pipe_oor       <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_tag   <= '0;
      mem_resp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (rd_fire) rd_count <= rd_count + 32'd1;
      if (beat_fire && !wr_oor) wr_count <= wr_count + 32'd1;
      if ((rd_fire || wr_fire) && req_oor) addr_err <= 1'b1;
      if (wr_fire) begin
        wr_row <= req_row;
        wr_oor <= req_oor;
      end
      pipe_vld[0] <= rd_fire;
      pipe_oor[0] <= req_oor;
      pipe_tag[0] <= mem_req_tag;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_oor[i] <= pipe_oor[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      mem_resp_valid <= pipe_vld[LATENCY-1];
      if (pipe_vld[LATENCY-1]) begin
        mem_resp_tag  <= pipe_tag[LATENCY-1];
        mem_resp_data <= pipe_oor[LATENCY-1] ? '0 : pipe_dat[LATENCY-1];
      end
    end
  end

  // RAM and read-data pipeline carry no reset so they map onto block RAM and plain flops.
  always_ff @(posedge clk) begin
    if (beat_fire && !wr_oor) begin
      for (int b = 0; b < NBYTES; b++)
        if (mem_req_data_mask[b]) ram[wr_row][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
    end
    if (rd_fire) pipe_dat[0] <= ram[req_row];
    for (int i = 1; i < LATENCY; i++) pipe_dat[i] <= pipe_dat[i-1];
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Randomized self-checking bench for ext_mem_responder against a queue/array memory model.
module tb_ext_mem_responder;
  localparam int LAT = 4;

  typedef struct packed {
    int           at;
    logic [4:0]   tag;
    logic [127:0] data;
  } resp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         mem_req_valid = 1'b0;
  logic         mem_req_ready;
  logic         mem_req_rw = 1'b0;
  logic [27:0]  mem_req_addr = '0;
  logic [4:0]   mem_req_tag = '0;
  logic         mem_req_data_valid = 1'b0;
  logic         mem_req_data_ready;
  logic [127:0] mem_req_data_bits = '0;
  logic [15:0]  mem_req_data_mask = '0;
  logic         mem_resp_valid;
  logic [4:0]   mem_resp_tag;
  logic [127:0] mem_resp_data;
  logic [31:0]  rd_count, wr_count;
  logic         addr_err;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int rd_m = 0;
  int wr_m = 0;
  resp_t obsq[$];
  resp_t expq[$];
  logic [127:0] mdl [int];

  ext_mem_responder #(.ADDR_BITS(28), .DATA_BITS(128), .TAG_BITS(5), .DEPTH_LOG2(12), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .rd_count(rd_count), .wr_count(wr_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) if (mem_resp_valid === 1'b1) obsq.push_back({edge_cnt, mem_resp_tag, mem_resp_data});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  // Drives one request from just after a clock edge; returns the edge on which it was accepted.
  task automatic issue(input bit rw, input logic [27:0] a, input logic [4:0] t, output int acc);
    int n;
    n = 0;
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = a; mem_req_tag = t;
    while (mem_req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL req_timeout: ready=%b, want 1", mem_req_ready); end
    @(posedge clk); #1;
    acc = edge_cnt;
    mem_req_valid = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input logic [15:0] m);
    int n;
    n = 0;
    mem_req_data_valid = 1'b1; mem_req_data_bits = d; mem_req_data_mask = m;
    while (mem_req_data_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin total++; bad++; $display("FAIL beat_timeout: data_ready=%b, want 1", mem_req_data_ready); end
    @(posedge clk); #1;
    mem_req_data_valid = 1'b0;
  endtask

  // Reference memory: a line is replaced byte by byte wherever the mask bit is set.
  task automatic model_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    logic [127:0] line;
    int row;
    row = int'(a[11:0]);
    if (a >= 28'h1000) return;
    line = mdl.exists(row) ? mdl[row] : 'x;
    for (int b = 0; b < 16; b++) if (m[b]) line[b*8 +: 8] = d[b*8 +: 8];
    mdl[row] = line;
    wr_m++;
  endtask

  task automatic wr(input logic [27:0] a, input logic [4:0] t, input logic [127:0] d, input logic [15:0] m);
    int acc;
    issue(1'b1, a, t, acc);
    beat(d, m);
    model_write(a, d, m);
  endtask

  task automatic rd(input logic [27:0] a, input logic [4:0] t, output int acc);
    issue(1'b0, a, t, acc);
    rd_m++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    total++; if (mem_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b, want 0", mem_req_ready); end
    total++; if (mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL rst_data_ready: got %b, want 0", mem_req_data_ready); end
    total++; if ({mem_resp_valid, mem_resp_tag, mem_resp_data} !== '0) begin bad++; $display("FAIL rst_resp: got v=%b tag=%0d data=%h, want all 0", mem_resp_valid, mem_resp_tag, mem_resp_data); end
    total++; if ({rd_count, wr_count, addr_err} !== '0) begin bad++; $display("FAIL rst_counts: got rd=%0d wr=%0d err=%b, want 0 0 0", rd_count, wr_count, addr_err); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (mem_req_ready !== 1'b1 || mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got rdy=%b drdy=%b, want 1 0", mem_req_ready, mem_req_data_ready); end
  endtask

  task automatic test_write_read;
    int acc;
    resp_t e, o;
    wr(28'h10, 5'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF);
    rd(28'h10, 5'd7, acc);
    expq.push_back({acc + LAT, 5'd7, 128'h00112233_44556677_8899AABB_CCDDEEFF});
    repeat (LAT + 2) @(posedge clk); #1;
    while (expq.size() > 0) begin
      e = expq.pop_front(); total++;
      if (obsq.size() == 0) begin bad++; $display("FAIL wr_rd_resp: none, want tag=%0d at edge %0d", e.tag, e.at); end
      else begin o = obsq.pop_front(); if (o !== e) begin bad++; $display("FAIL wr_rd_resp: got edge=%0d tag=%0d data=%h, want edge=%0d tag=%0d data=%h", o.at, o.tag, o.data, e.at, e.tag, e.data); end end
    end
    total++; if (obsq.size() != 0) begin bad++; $display("FAIL wr_rd_extra: got %0d extra responses, want 0", obsq.size()); obsq.delete(); end
    total++; if (wr_count !== 32'd1 || rd_count !== 32'd1) begin bad++; $display("FAIL wr_rd_counts: got wr=%0d rd=%0d, want 1 1", wr_count, rd_count); end
  endtask

  task automatic test_masked_merge;
    int acc;
    resp_t e, o;
    wr(28'h20, 5'd0, {128{1'b1}}, 16'hFFFF);
    wr(28'h20, 5'd1, 128'h0, 16'h00F0);
    rd(28'h20, 5'd4, acc);
    expq.push_back({acc + LAT, 5'd4, 128'hFFFFFFFF_FFFFFFFF_00000000_FFFFFFFF});
    repeat (LAT + 2) @(posedge clk); #1;
    while (expq.size() > 0) begin
      e = expq.pop_front(); total++;
      if (obsq.size() == 0) begin bad++; $display("FAIL merge_resp: none, want tag=%0d", e.tag); end
      else begin o = obsq.pop_front(); if (o !== e) begin bad++; $display("FAIL merge_resp: got edge=%0d tag=%0d data=%h, want edge=%0d tag=%0d data=%h", o.at, o.tag, o.data, e.at, e.tag, e.data); end end
    end
    total++; if (obsq.size() != 0) begin bad++; $display("FAIL merge_extra: got %0d extra responses, want 0", obsq.size()); obsq.delete(); end
  endtask

  task automatic test_back_to_back;
    int acc, first;
    resp_t e, o;
    logic [27:0] a;
    for (int i = 0; i < 6; i++) begin
      a = (i % 2 == 0) ? 28'h10 : 28'h20;
      rd(a, 5'(i), acc);
      if (i == 0) first = acc;
      total++; if (acc != first + i) begin bad++; $display("FAIL b2b_accept: read %0d got edge %0d, want %0d", i, acc, first + i); end
      expq.push_back({acc + LAT, 5'(i), mdl[int'(a)]});
    end
    repeat (LAT + 2) @(posedge clk); #1;
    while (expq.size() > 0) begin
      e = expq.pop_front(); total++;
      if (obsq.size() == 0) begin bad++; $display("FAIL b2b_resp: none, want tag=%0d", e.tag); end
      else begin o = obsq.pop_front(); if (o !== e) begin bad++; $display("FAIL b2b_resp: got edge=%0d tag=%0d data=%h, want edge=%0d tag=%0d data=%h", o.at, o.tag, o.data, e.at, e.tag, e.data); end end
    end
    total++; if (obsq.size() != 0) begin bad++; $display("FAIL b2b_extra: got %0d extra responses, want 0", obsq.size()); obsq.delete(); end
  endtask

  task automatic test_write_handshake;
    int acc, d_edge;
    resp_t e, o;
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    // An early beat in IDLE must not be taken.
    mem_req_data_valid = 1'b1; mem_req_data_bits = d; mem_req_data_mask = 16'hFFFF;
    total++; if (mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL early_beat: data_ready=%b, want 0", mem_req_data_ready); end
    @(posedge clk); #1;
    mem_req_data_valid = 1'b0;
    total++; if (wr_count !== 32'(wr_m)) begin bad++; $display("FAIL early_beat_cnt: wr_count=%0d, want %0d", wr_count, wr_m); end
    issue(1'b1, 28'h30, 5'd2, acc);
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 28'h30; mem_req_tag = 5'd11;
    for (int i = 0; i < 5; i++) begin
      total++; if (mem_req_ready !== 1'b0 || mem_req_data_ready !== 1'b1) begin bad++; $display("FAIL wdata_hold: cycle %0d rdy=%b drdy=%b, want 0 1", i, mem_req_ready, mem_req_data_ready); end
      @(posedge clk); #1;
    end
    beat(d, 16'hFFFF);
    d_edge = edge_cnt;
    model_write(28'h30, d, 16'hFFFF);
    total++; if (rd_count !== 32'(rd_m)) begin bad++; $display("FAIL wdata_rd_blocked: rd_count=%0d, want %0d", rd_count, rd_m); end
    total++; if (mem_req_ready !== 1'b1) begin bad++; $display("FAIL wdata_release: ready=%b, want 1", mem_req_ready); end
    @(posedge clk); #1;
    acc = edge_cnt; mem_req_valid = 1'b0; rd_m++;
    total++; if (acc != d_edge + 1) begin bad++; $display("FAIL wdata_rd_edge: accepted at %0d, want %0d", acc, d_edge + 1); end
    expq.push_back({acc + LAT, 5'd11, d});
    repeat (LAT + 2) @(posedge clk); #1;
    while (expq.size() > 0) begin
      e = expq.pop_front(); total++;
      if (obsq.size() == 0) begin bad++; $display("FAIL hs_resp: none, want tag=%0d", e.tag); end
      else begin o = obsq.pop_front(); if (o !== e) begin bad++; $display("FAIL hs_resp: got edge=%0d tag=%0d data=%h, want edge=%0d tag=%0d data=%h", o.at, o.tag, o.data, e.at, e.tag, e.data); end end
    end
    total++; if (obsq.size() != 0) begin bad++; $display("FAIL hs_extra: got %0d extra responses, want 0", obsq.size()); obsq.delete(); end
  endtask

  task automatic test_out_of_range;
    int acc;
    resp_t e, o;
    rd(28'h1000, 5'd9, acc);
    expq.push_back({acc + LAT, 5'd9, 128'h0});
    wr(28'h2010, 5'd5, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    total++; if (wr_count !== 32'(wr_m)) begin bad++; $display("FAIL oor_wr_cnt: wr_count=%0d, want %0d", wr_count, wr_m); end
    rd(28'h10, 5'd1, acc);
    expq.push_back({acc + LAT, 5'd1, mdl[16]});
    repeat (LAT + 2) @(posedge clk); #1;
    while (expq.size() > 0) begin
      e = expq.pop_front(); total++;
      if (obsq.size() == 0) begin bad++; $display("FAIL oor_resp: none, want tag=%0d", e.tag); end
      else begin o = obsq.pop_front(); if (o !== e) begin bad++; $display("FAIL oor_resp: got edge=%0d tag=%0d data=%h, want edge=%0d tag=%0d data=%h", o.at, o.tag, o.data, e.at, e.tag, e.data); end end
    end
    total++; if (obsq.size() != 0) begin bad++; $display("FAIL oor_extra: got %0d extra responses, want 0", obsq.size()); obsq.delete(); end
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_sticky: addr_err=%b, want 1", addr_err); end
  endtask

  task automatic test_random;
    int acc;
    resp_t e, o;
    logic [27:0] a;
    logic [4:0] t;
    for (int i = 0; i < 8; i++) wr(28'h100 + 28'(i), 5'(i), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    for (int i = 0; i < 60; i++) begin
      a = 28'h100 + 28'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        wr(a, 5'($urandom), {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
      end else begin
        t = 5'($urandom);
        rd(a, t, acc);
        expq.push_back({acc + LAT, t, mdl[int'(a)]});
      end
    end
    repeat (LAT + 2) @(posedge clk); #1;
    while (expq.size() > 0) begin
      e = expq.pop_front(); total++;
      if (obsq.size() == 0) begin bad++; $display("FAIL rand_resp: none, want tag=%0d at edge %0d", e.tag, e.at); end
      else begin o = obsq.pop_front(); if (o !== e) begin bad++; $display("FAIL rand_resp: got edge=%0d tag=%0d data=%h, want edge=%0d tag=%0d data=%h", o.at, o.tag, o.data, e.at, e.tag, e.data); end end
    end
    total++; if (obsq.size() != 0) begin bad++; $display("FAIL rand_extra: got %0d extra responses, want 0", obsq.size()); obsq.delete(); end
    total++; if (rd_count !== 32'(rd_m) || wr_count !== 32'(wr_m)) begin bad++; $display("FAIL rand_counts: got rd=%0d wr=%0d, want %0d %0d", rd_count, wr_count, rd_m, wr_m); end
  endtask

  task automatic test_async_reset;
    int acc;
    rd(28'h10, 5'd20, acc);
    rd(28'h20, 5'd21, acc);
    issue(1'b1, 28'h40, 5'd22, acc);
    total++; if (mem_req_data_ready !== 1'b1) begin bad++; $display("FAIL arst_setup: data_ready=%b, want 1", mem_req_data_ready); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (mem_req_ready !== 1'b0 || mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL arst_ready: rdy=%b drdy=%b, want 0 0", mem_req_ready, mem_req_data_ready); end
    total++; if ({mem_resp_valid, mem_resp_tag, mem_resp_data} !== '0) begin bad++; $display("FAIL arst_resp: v=%b tag=%0d data=%h, want all 0", mem_resp_valid, mem_resp_tag, mem_resp_data); end
    total++; if ({rd_count, wr_count, addr_err} !== '0) begin bad++; $display("FAIL arst_counts: rd=%0d wr=%0d err=%b, want 0 0 0", rd_count, wr_count, addr_err); end
    @(negedge clk) reset_n = 1'b1;
    repeat (LAT + 4) @(posedge clk); #1;
    total++; if (obsq.size() != 0) begin bad++; $display("FAIL arst_flush: got %0d responses, want 0", obsq.size()); obsq.delete(); end
    total++; if (mem_req_ready !== 1'b1 || mem_req_data_ready !== 1'b0) begin bad++; $display("FAIL arst_idle: rdy=%b drdy=%b, want 1 0", mem_req_ready, mem_req_data_ready); end
    total++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin bad++; $display("FAIL arst_cnt_after: rd=%0d wr=%0d, want 0 0", rd_count, wr_count); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_masked_merge;
    test_back_to_back;
    test_write_handshake;
    test_out_of_range;
    test_random;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
